// File: rtl/mb_rtu_ctrl.sv
// Modbus RTU frame controller: T3.5 silence framing for receive into an external
// frame RAM, and byte-by-byte transmit from that RAM with a post-frame silence.
module mb_rtu_ctrl #(
    parameter int FRAME_MAX = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] t35_cycles,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    input  logic        tx_start,
    input  logic [8:0]  tx_len,
    input  logic        tx_ready,
    input  logic        tx_empty,
    output logic        buf_wr_en,
    output logic [7:0]  buf_wr_addr,
    output logic [7:0]  buf_wr_data,
    output logic [7:0]  buf_rd_addr,
    input  logic [7:0]  buf_rd_data,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    output logic        rx_enable,
    output logic        tx_enable,
    output logic        frame_ready,
    output logic [8:0]  frame_len,
    output logic        rx_error,
    output logic        tx_done,
    output logic        tx_reject
);

    typedef enum logic [2:0] {INIT, IDLE, RCV, RXERR, XMIT, TXWAIT} state_t;
    localparam logic [8:0] FMAX = 9'(FRAME_MAX);

    state_t      state, state_n;
    logic [23:0] timer, timer_n, t35_q, t35_eff, t35_last;
    logic [8:0]  count, count_n, idx, idx_n, len_q, len_q_n;
    logic        expire, len_ok;
    logic        wr_en_n, tx_valid_n, frame_ready_n, rx_error_n, tx_done_n, tx_reject_n, rx_en_n;
    logic [7:0]  wr_addr_n, wr_data_n, rd_addr_n;
    logic [8:0]  frame_len_n;

    // The interval is taken live while the timer sits at 0 and held for the rest of the run.
    assign t35_eff  = (timer == 24'd0) ? t35_cycles : t35_q;
    assign t35_last = (t35_eff == 24'd0) ? 24'd0 : t35_eff - 24'd1;
    assign expire   = (timer == t35_last);
    assign len_ok   = (tx_len != 9'd0) && (tx_len <= FMAX);

    // The RAM output register doubles as the byte register: the read address is frozen
    // while tx_valid is high, so the byte stays stable until accepted.
    assign tx_byte  = tx_valid ? buf_rd_data : 8'h00;

    always_comb begin
        state_n       = state;
        timer_n       = timer + 24'd1;
        count_n       = count;
        idx_n         = idx;
        len_q_n       = len_q;
        wr_en_n       = 1'b0;
        wr_addr_n     = buf_wr_addr;
        wr_data_n     = buf_wr_data;
        rd_addr_n     = buf_rd_addr;
        tx_valid_n    = tx_valid;
        frame_ready_n = 1'b0;
        frame_len_n   = frame_len;
        rx_error_n    = 1'b0;
        tx_done_n     = 1'b0;
        tx_reject_n   = tx_start;
        case (state)
            INIT: begin
                if (rx_valid) timer_n = '0;
                else if (expire) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            end
            IDLE: begin
                timer_n = '0;
                if (rx_valid) begin
                    wr_en_n   = 1'b1;
                    wr_addr_n = 8'd0;
                    wr_data_n = rx_byte;
                    count_n   = 9'd1;
                    state_n   = RCV;
                end else if (tx_start && len_ok) begin
                    tx_reject_n = 1'b0;
                    len_q_n     = tx_len;
                    idx_n       = '0;
                    rd_addr_n   = 8'd0;
                    tx_valid_n  = 1'b0;
                    state_n     = XMIT;
                end
            end
            RCV: begin
                if (rx_valid) begin
                    timer_n = '0;
                    if (count < FMAX) begin
                        wr_en_n   = 1'b1;
                        wr_addr_n = count[7:0];
                        wr_data_n = rx_byte;
                        count_n   = count + 9'd1;
                    end else begin
                        state_n = RXERR;
                    end
                end else if (expire) begin
                    frame_ready_n = 1'b1;
                    frame_len_n   = count;
                    state_n       = IDLE;
                    timer_n       = '0;
                end
            end
            RXERR: begin
                if (rx_valid) timer_n = '0;
                else if (expire) begin
                    rx_error_n = 1'b1;
                    state_n    = IDLE;
                    timer_n    = '0;
                end
            end
            XMIT: begin
                timer_n = '0;
                // Address was presented last cycle, so RAM data is valid from now on.
                if (!tx_valid) tx_valid_n = 1'b1;
                else if (tx_ready) begin
                    tx_valid_n = 1'b0;
                    if (idx == len_q - 9'd1) state_n = TXWAIT;
                    else begin
                        idx_n     = idx + 9'd1;
                        rd_addr_n = 8'(idx + 9'd1);
                    end
                end
            end
            TXWAIT: begin
                if (!tx_empty) timer_n = '0;
                else if (expire) begin
                    tx_done_n = 1'b1;
                    state_n   = IDLE;
                    timer_n   = '0;
                end
            end
            default: begin
                state_n = INIT;
                timer_n = '0;
            end
        endcase
        rx_en_n = !((state_n == XMIT) || (state_n == TXWAIT));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= INIT;
            timer       <= '0;
            t35_q       <= '0;
            count       <= '0;
            idx         <= '0;
            len_q       <= '0;
            buf_wr_en   <= 1'b0;
            buf_wr_addr <= '0;
            buf_wr_data <= '0;
            buf_rd_addr <= '0;
            tx_valid    <= 1'b0;
            rx_enable   <= 1'b1;
            tx_enable   <= 1'b0;
            frame_ready <= 1'b0;
            frame_len   <= '0;
            rx_error    <= 1'b0;
            tx_done     <= 1'b0;
            tx_reject   <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            if (timer == 24'd0) t35_q <= t35_cycles;
            count       <= count_n;
            idx         <= idx_n;
            len_q       <= len_q_n;
            buf_wr_en   <= wr_en_n;
            buf_wr_addr <= wr_addr_n;
            buf_wr_data <= wr_data_n;
            buf_rd_addr <= rd_addr_n;
            tx_valid    <= tx_valid_n;
            rx_enable   <= rx_en_n;
            tx_enable   <= ~rx_en_n;
            frame_ready <= frame_ready_n;
            frame_len   <= frame_len_n;
            rx_error    <= rx_error_n;
            tx_done     <= tx_done_n;
            tx_reject   <= tx_reject_n;
        end
    end

endmodule

// File: doc/mb_rtu_ctrl.md
MB_RTU_CTRL -- requirements
Module: mb_rtu_ctrl

Interface
REQ-001 SHALL have parameter FRAME_MAX, default 256, meaning maximum frame length in bytes; legal range 2..256.
REQ-002 SHALL have port clk, input, 1 bit, meaning the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, meaning reset; asynchronous and active-high.
REQ-004 SHALL have port t35_cycles, input, 24 bits, meaning the T3.5 silent interval in clk cycles; sampled whenever the timer restarts.
REQ-005 SHALL have port rx_valid, input, 1 bit, meaning a one-cycle pulse from the UART receiver for each received byte.
REQ-006 SHALL have port rx_byte, input, 8 bits, meaning the received byte, valid when rx_valid=1.
REQ-007 SHALL have port tx_start, input, 1 bit, meaning a one-cycle pulse requesting transmission of a frame.
REQ-008 SHALL have port tx_len, input, 9 bits, meaning the byte count of that frame, sampled with tx_start.
REQ-009 SHALL have port tx_ready, input, 1 bit, meaning the UART transmitter accepts a byte this cycle.
REQ-010 SHALL have port tx_empty, input, 1 bit, meaning the UART shift register is idle.
REQ-011 SHALL have port buf_wr_en / buf_wr_addr / buf_wr_data, outputs, 1/8/8 bits, meaning the write port of the external frame RAM.
REQ-012 SHALL have port buf_rd_addr, output, 8 bits, and buf_rd_data, input, 8 bits, meaning the read port of the frame RAM with 1-cycle read latency.
REQ-013 SHALL have port tx_valid / tx_byte, outputs, 1/8 bits, meaning a byte offered to the UART.
REQ-014 SHALL have port rx_enable / tx_enable, outputs, 1 bit each, meaning the enables of the UART receiver and driver.
REQ-015 SHALL have port frame_ready / frame_len, outputs, 1/9 bits, meaning a one-cycle pulse plus the length of a completed received frame.
REQ-016 SHALL have ports rx_error, tx_done and tx_reject, outputs, 1 bit each, meaning one-cycle status pulses.

Function
REQ-017 SHALL use FSM states INIT, IDLE, RCV, RXERR, XMIT and TXWAIT.
REQ-018 Timer SHALL count from 0 and expire when count = t35_cycles-1; t35_cycles=0 SHALL be treated as 1.
REQ-019 A timer restart SHALL load count 0 in the same cycle.
REQ-020 INIT: rx_valid SHALL restart the timer and its byte SHALL be discarded; expiry SHALL go to IDLE.
REQ-021 IDLE with rx_valid: SHALL write rx_byte at address 0, set count=1, restart the timer and go to RCV.
REQ-022 IDLE with tx_start and 1<=tx_len<=FRAME_MAX: SHALL go to XMIT with rx_enable=0 and tx_enable=1, registered on the next cycle.
REQ-023 Any other tx_len SHALL produce a tx_reject pulse and no state change.
REQ-024 Simultaneous rx_valid and tx_start in IDLE: receive SHALL win and tx_start SHALL get a tx_reject pulse.
REQ-025 tx_start in any state other than IDLE SHALL produce a tx_reject pulse.
REQ-026 RCV with rx_valid and count<FRAME_MAX: SHALL write at address count, increment count and restart the timer.
REQ-027 RCV with rx_valid and count=FRAME_MAX: SHALL write nothing, restart the timer and go to RXERR.
REQ-028 RCV on timer expiry: SHALL pulse frame_ready with frame_len=count for one cycle, then go to IDLE.
REQ-029 frame_len SHALL hold its value until the next frame_ready.
REQ-030 RXERR: rx_valid SHALL restart the timer; expiry SHALL pulse rx_error, go to IDLE and produce no frame_ready.
REQ-031 XMIT: buf_rd_addr SHALL equal the transmit index.
REQ-032 XMIT: tx_valid SHALL be asserted one cycle after each address is presented, with tx_byte=buf_rd_data held stable until tx_valid&&tx_ready.
REQ-033 XMIT: on each acceptance the index SHALL increment, with one bubble cycle allowed between bytes.
REQ-034 XMIT: after acceptance of byte tx_len-1, tx_valid SHALL drop and the FSM SHALL go to TXWAIT.
REQ-035 TXWAIT: the timer SHALL be held at 0 while tx_empty=0 and run while tx_empty=1.
REQ-036 TXWAIT on expiry: SHALL pulse tx_done, set tx_enable=0 and rx_enable=1, and go to IDLE.
REQ-037 rx_valid in XMIT or TXWAIT SHALL be ignored.
REQ-038 No buffer write SHALL ever occur in INIT, RXERR, XMIT or TXWAIT.
REQ-039 rx_enable SHALL be 1 in INIT, IDLE, RCV and RXERR, and 0 in XMIT and TXWAIT.
REQ-040 tx_enable SHALL be the complement of rx_enable.
REQ-041 All outputs SHALL be registered.

Reset
REQ-042 rst=1 SHALL, asynchronously, set state=INIT, timer=0, count=0 and index=0.
REQ-043 rst=1 SHALL, asynchronously, set rx_enable=1, tx_enable=0, frame_len=0 and every other output to 0.
REQ-044 Reset mid-frame or mid-transmit SHALL abandon the operation with no frame_ready or tx_done pulse.
REQ-045 After reset release, a full T3.5 of silence SHALL be required before IDLE.

Verification
REQ-046 Startup: t35_cycles=10, reset released, no rx -> IDLE reached 10 cycles later; rx_valid at cycle 5 delays IDLE to cycle 15.
REQ-047 Receive: 8 bytes 0x01,0x03,0x00,0x00,0x00,0x0A,0xC5,0xCD one per 20 cycles, t35_cycles=30 -> RAM[0..7] written in order; frame_ready once with frame_len=8 exactly 30 cycles after the last rx_valid.
REQ-048 Overrun: FRAME_MAX=4, 6 bytes sent -> only addresses 0..3 written; rx_error pulse after silence; no frame_ready.
REQ-049 Transmit: tx_start with tx_len=3, RAM=0xAA,0xBB,0xCC, tx_ready toggling 1-0 -> tx_byte sequence AA,BB,CC with no duplicates; tx_enable=1 throughout.
REQ-050 Transmit end: tx_empty rising 5 cycles after the last byte, t35_cycles=10 -> tx_done pulse 10 cycles after tx_empty rises; tx_enable falls in the same cycle as tx_done.
REQ-051 Rejects: tx_len=0, tx_len=257, tx_start during RCV, and simultaneous rx_valid+tx_start in IDLE -> tx_reject pulse each time; the receive proceeds normally.
